commit_stage: RTL and testbench
===============================

Name: commit_stage

Overview:
- In-order retirement stage directly downstream of the reorder buffer. Consumes the ROB head entry and its ready flag.
- For register-producing instructions: writes the architectural register file and clears the map-table entry.
- For stores: drives a single-outstanding memory write handshake.
- Returns a one-cycle retire pulse that tells the ROB to advance its head.

Parameters:
- STORE_TIMEOUT, 255: cycles a store may wait for grant before the sticky store_timeout flag sets.
- CNT_W, 8: width of the internal store wait counter. Must satisfy 2^CNT_W > STORE_TIMEOUT.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- head_entry  input  ROB_ENTRY  current ROB head (valid, wr_mem, dest_reg, dest_addr, value, ...)
- head_ready  input  1  head value and address both ready
- head_tag  input  `ROB_TAG_LEN  ROB tag of head
- store_gnt  input  1  memory accepted the store this cycle
- retire  output  1  head committed this cycle; ROB advances head on the next edge
- rf_wr_en  output  1  register file write enable
- rf_wr_idx  output  5  register file write index
- rf_wr_data  output  `XLEN  register file write data
- mt_clear_en  output  1  map table: clear entry mt_clear_reg if it still holds mt_clear_tag
- mt_clear_reg  output  5  map table register index
- mt_clear_tag  output  `ROB_TAG_LEN  map table tag to match
- store_req  output  1  memory write request
- store_addr  output  `XLEN  store address
- store_data  output  `XLEN  store data
- store_timeout  output  1  sticky error flag
- busy  output  1  FSM is in ST_WAIT

Behaviour:
- FSM states: IDLE, ST_WAIT. State, latched store addr/data/tag and wait counter are registered. retire, rf_* and mt_* are combinational from state and inputs.
- commit_ok = head_entry.valid && head_ready.
- IDLE, commit_ok, !wr_mem:
  - retire=1 the same cycle.
  - rf_wr_en=1, rf_wr_idx=dest_reg, rf_wr_data=value.
  - mt_clear_en=1, mt_clear_reg=dest_reg, mt_clear_tag=head_tag.
  - If dest_reg == `ZERO_REG: retire=1 but rf_wr_en=0 and mt_clear_en=0.
  - Stay IDLE. Back-to-back commits of one register instruction per cycle are supported.
- IDLE, commit_ok, wr_mem:
  - retire=0. Latch store_addr=dest_addr, store_data=value, latched tag=head_tag.
  - Clear the wait counter and go to ST_WAIT.
- ST_WAIT:
  - store_req=1, busy=1, retire=0 unless granted.
  - store_gnt=1: retire=1 that cycle, go to IDLE. Stores therefore take at least 2 cycles from ready to retire.
  - store_gnt=0: wait counter increments, saturating at 2^CNT_W-1. store_timeout sets when the counter reaches STORE_TIMEOUT and stays set until reset.
  - head_entry/head_tag are ignored while in ST_WAIT; the ROB head is stable until retire.
- IDLE with !commit_ok: all enables 0, no state change.
- store_req is 0 outside ST_WAIT. store_addr/store_data hold their last latched values.
- Reset (at any time, including mid-store): state=IDLE, store_req=0, store_addr=0, store_data=0, counter=0, store_timeout=0, busy=0.
  - retire, rf_wr_en and mt_clear_en are forced to 0 during the reset cycle.
  - A store pending at reset is dropped, with no grant expected.
- Simultaneous commit_ok and store_gnt in IDLE: store_gnt is ignored, since no request is outstanding.

Optional Feature:
- Macro COMMIT_STATS_EN.
- When defined, add outputs:
  - commit_count[31:0]: increments on every retire.
  - store_count[31:0]: increments on every store retire.
  - stall_cycles[31:0]: increments every ST_WAIT cycle with store_gnt=0.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then head_entry {valid=1, wr_mem=0, dest_reg=5, value=32'hDEADBEEF}, head_ready=1, head_tag=2 -> same cycle: retire=1, rf_wr_en=1, rf_wr_idx=5, rf_wr_data=DEADBEEF, mt_clear_en=1, mt_clear_tag=2.
- Register instruction with dest_reg=0, head_ready=1 -> retire=1, rf_wr_en=0, mt_clear_en=0.
- Store {wr_mem=1, dest_addr=32'h100, value=32'h55}, ready, store_gnt held 0 for 3 cycles then 1 -> store_req=1 from cycle+1 with addr 0x100 and data 0x55; retire=1 only in the grant cycle; then store_req=0 and busy=0; stall_cycles=3 (COMMIT_STATS_EN).
- Store waiting with STORE_TIMEOUT=4 and store_gnt=0 -> store_timeout rises after 4 waiting cycles and stays 1 after a later grant, until reset.
- Store in ST_WAIT, reset asserted for 1 cycle -> next cycle state IDLE, store_req=0, store_addr=0, retire=0.
- 4 consecutive ready register instructions (tags 0..3) -> 4 retire pulses in 4 cycles; commit_count=4.

Source files
------------

// File: rtl/commit_stage_if.sv
// commit_stage_if: bundle between the ROB head / memory side and commit_stage.
//
// Handshakes:
//   ROB head: the head is offered when head_entry.valid && head_ready.
//     It is consumed on a cycle where retire=1, and the ROB advances on that edge.
//   Store:    store_req stays high until a cycle with store_gnt=1.
//     That cycle completes the single outstanding write.
//     store_gnt is meaningless while store_req=0.
//
// Signals (direction as seen by commit_stage, modport slave):
//   in : head_entry, head_ready, head_tag, store_gnt
//   out: retire, rf_wr_en/idx/data, mt_clear_en/reg/tag, store_req,
//        store_addr, store_data, store_tag, store_timeout, busy, state_dbg
//   out (COMMIT_STATS_EN only): commit_count, store_count, stall_cycles
// Optional macro: COMMIT_STATS_EN.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

interface commit_stage_if;
  typedef struct packed {
    logic              valid;
    logic              wr_mem;
    logic [4:0]        dest_reg;
    logic [`XLEN-1:0]  dest_addr;
    logic [`XLEN-1:0]  value;
  } rob_entry_t;

  rob_entry_t              head_entry;
  logic                    head_ready;
  logic [`ROB_TAG_LEN-1:0] head_tag;
  logic                    store_gnt;

  logic                    retire;
  logic                    rf_wr_en;
  logic [4:0]              rf_wr_idx;
  logic [`XLEN-1:0]        rf_wr_data;
  logic                    mt_clear_en;
  logic [4:0]              mt_clear_reg;
  logic [`ROB_TAG_LEN-1:0] mt_clear_tag;
  logic                    store_req;
  logic [`XLEN-1:0]        store_addr;
  logic [`XLEN-1:0]        store_data;
  logic [`ROB_TAG_LEN-1:0] store_tag;
  logic                    store_timeout;
  logic                    busy;
  logic                    state_dbg;
`ifdef COMMIT_STATS_EN
  logic [31:0]             commit_count;
  logic [31:0]             store_count;
  logic [31:0]             stall_cycles;
`endif

  modport slave (
    input  head_entry, head_ready, head_tag, store_gnt,
    output retire, rf_wr_en, rf_wr_idx, rf_wr_data,
           mt_clear_en, mt_clear_reg, mt_clear_tag,
           store_req, store_addr, store_data, store_tag,
           store_timeout, busy, state_dbg
`ifdef COMMIT_STATS_EN
           , commit_count, store_count, stall_cycles
`endif
  );

  modport master (
    output head_entry, head_ready, head_tag, store_gnt,
    input  retire, rf_wr_en, rf_wr_idx, rf_wr_data,
           mt_clear_en, mt_clear_reg, mt_clear_tag,
           store_req, store_addr, store_data, store_tag,
           store_timeout, busy, state_dbg
`ifdef COMMIT_STATS_EN
           , commit_count, store_count, stall_cycles
`endif
  );
endinterface

// File: rtl/commit_stage.sv
// commit_stage: in-order retirement downstream of the reorder buffer.
//
// Register instructions retire in the cycle they are offered. They write the RF
// and clear the map-table entry; writes to the zero register are suppressed.
// Stores latch addr/data/tag into ST_WAIT and hold store_req until granted.
// They retire in the grant cycle.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : commit_stage_if.slave (ROB head, RF/map-table writes,
//                  store handshake, status; see the interface header)
// Parameters:
//   STORE_TIMEOUT : grant-wait cycles before the sticky store_timeout flag sets
//   CNT_W         : wait counter width, 2**CNT_W > STORE_TIMEOUT
// Optional macro: COMMIT_STATS_EN adds commit_count, store_count, stall_cycles.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

module commit_stage #(
  parameter int STORE_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input logic           clock,
  input logic           reset,
  commit_stage_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [`XLEN-1:0]        addr_q, addr_d;
  logic [`XLEN-1:0]        data_q, data_d;
  logic [`ROB_TAG_LEN-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;

  logic commit_ok, reg_commit, store_done, writes_reg;

  assign commit_ok = bus.head_entry.valid && bus.head_ready;

  // Gate with reset so nothing retires or writes during the reset cycle.
  assign reg_commit = !reset && (state_q == IDLE) && commit_ok && !bus.head_entry.wr_mem;
  assign store_done = !reset && (state_q == ST_WAIT) && bus.store_gnt;
  assign writes_reg = reg_commit && (bus.head_entry.dest_reg != `ZERO_REG);

  assign bus.retire        = reg_commit || store_done;
  assign bus.rf_wr_en      = writes_reg;
  assign bus.rf_wr_idx     = bus.head_entry.dest_reg;
  assign bus.rf_wr_data    = bus.head_entry.value;
  assign bus.mt_clear_en   = writes_reg;
  assign bus.mt_clear_reg  = bus.head_entry.dest_reg;
  assign bus.mt_clear_tag  = bus.head_tag;
  assign bus.store_req     = (state_q == ST_WAIT);
  assign bus.busy          = (state_q == ST_WAIT);
  assign bus.state_dbg     = state_q;
  assign bus.store_addr    = addr_q;
  assign bus.store_data    = data_q;
  assign bus.store_tag     = tag_q;
  assign bus.store_timeout = timeout_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        // A grant here has no outstanding request and is ignored.
        if (commit_ok && bus.head_entry.wr_mem) begin
          addr_d  = bus.head_entry.dest_addr;
          data_d  = bus.head_entry.value;
          tag_d   = bus.head_tag;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.store_gnt) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          // Set on the same edge the counter reaches the limit.
          if (cnt_d >= CNT_W'(STORE_TIMEOUT)) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef COMMIT_STATS_EN
  logic [31:0] commit_cnt_q, store_cnt_q, stall_cnt_q;

  assign bus.commit_count = commit_cnt_q;
  assign bus.store_count  = store_cnt_q;
  assign bus.stall_cycles = stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      commit_cnt_q <= '0;
      store_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (bus.retire) commit_cnt_q <= commit_cnt_q + 32'd1;
      if (store_done) store_cnt_q  <= store_cnt_q + 32'd1;
      if ((state_q == ST_WAIT) && !bus.store_gnt) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: directed self-checking bench for commit_stage
// (STORE_TIMEOUT=4). Optional macro: COMMIT_STATS_EN enables counter checks.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif

module tb_commit_stage;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [`ROB_TAG_LEN-1:0] exp_q[$];
  logic [`ROB_TAG_LEN-1:0] exp_tag;

  commit_stage_if cif();

  commit_stage #(.STORE_TIMEOUT(4), .CNT_W(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (cif)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; drive inputs there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wm, input logic [4:0] rd,
                       input logic [`XLEN-1:0] addr, input logic [`XLEN-1:0] val,
                       input logic [`ROB_TAG_LEN-1:0] tg, input logic rdy, input logic gnt);
    cif.head_entry.valid     = v;
    cif.head_entry.wr_mem    = wm;
    cif.head_entry.dest_reg  = rd;
    cif.head_entry.dest_addr = addr;
    cif.head_entry.value     = val;
    cif.head_tag             = tg;
    cif.head_ready           = rdy;
    cif.store_gnt            = gnt;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
    step();
    // Offered register commit during reset must not retire or write.
    drive(1'b1, 1'b0, 5'd9, '0, 32'h1234, 4'd1, 1'b1, 1'b0);
    check_eq("reset_retire", cif.retire, 1'b0);
    check_eq("reset_rf_wr_en", cif.rf_wr_en, 1'b0);
    check_eq("reset_mt_clear_en", cif.mt_clear_en, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("reset_busy", cif.busy, 1'b0);
    check_eq("reset_store_req", cif.store_req, 1'b0);
    check_eq("reset_store_addr", cif.store_addr, 32'h0);
    check_eq("reset_store_data", cif.store_data, 32'h0);
    check_eq("reset_timeout", cif.store_timeout, 1'b0);
    check_eq("idle_no_commit_retire", cif.retire, 1'b0);

    // Register commit, same-cycle retire.
    step();
    drive(1'b1, 1'b0, 5'd5, '0, 32'hDEADBEEF, 4'd2, 1'b1, 1'b0);
    check_eq("reg_retire", cif.retire, 1'b1);
    check_eq("reg_rf_wr_en", cif.rf_wr_en, 1'b1);
    check_eq("reg_rf_wr_idx", cif.rf_wr_idx, 5'd5);
    check_eq("reg_rf_wr_data", cif.rf_wr_data, 32'hDEADBEEF);
    check_eq("reg_mt_clear_en", cif.mt_clear_en, 1'b1);
    check_eq("reg_mt_clear_reg", cif.mt_clear_reg, 5'd5);
    check_eq("reg_mt_clear_tag", cif.mt_clear_tag, 4'd2);

    // Zero register: retire without writes.
    step();
    drive(1'b1, 1'b0, 5'd0, '0, 32'h77, 4'd3, 1'b1, 1'b0);
    check_eq("zero_retire", cif.retire, 1'b1);
    check_eq("zero_rf_wr_en", cif.rf_wr_en, 1'b0);
    check_eq("zero_mt_clear_en", cif.mt_clear_en, 1'b0);

    // Not ready / not valid: nothing happens.
    step();
    drive(1'b1, 1'b0, 5'd6, '0, 32'h1, 4'd4, 1'b0, 1'b0);
    check_eq("notready_retire", cif.retire, 1'b0);
    check_eq("notready_rf_wr_en", cif.rf_wr_en, 1'b0);
    drive(1'b0, 1'b0, 5'd6, '0, 32'h1, 4'd4, 1'b1, 1'b0);
    check_eq("invalid_retire", cif.retire, 1'b0);
    check_eq("invalid_mt_clear_en", cif.mt_clear_en, 1'b0);

    // Stray grant in IDLE together with a register commit is ignored.
    drive(1'b1, 1'b0, 5'd7, '0, 32'h2, 4'd5, 1'b1, 1'b1);
    check_eq("idle_gnt_retire", cif.retire, 1'b1);
    step();
    drive(1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("idle_gnt_busy", cif.busy, 1'b0);

    // Store: 3 stalled cycles, grant on the 4th ST_WAIT cycle.
    step();
    drive(1'b1, 1'b1, 5'd0, 32'h100, 32'h55, 4'd7, 1'b1, 1'b0);
    check_eq("st_accept_retire", cif.retire, 1'b0);
    check_eq("st_accept_req", cif.store_req, 1'b0);
    check_eq("st_accept_rf_wr_en", cif.rf_wr_en, 1'b0);
    // Head contents during ST_WAIT must be ignored.
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 1'b0, 5'd3, 32'hBAD, 32'hBAD, 4'd9, 1'b1, 1'b0);
      check_eq("st_wait_req", cif.store_req, 1'b1);
      check_eq("st_wait_busy", cif.busy, 1'b1);
      check_eq("st_wait_retire", cif.retire, 1'b0);
      check_eq("st_wait_rf_wr_en", cif.rf_wr_en, 1'b0);
      check_eq("st_wait_addr", cif.store_addr, 32'h100);
      check_eq("st_wait_data", cif.store_data, 32'h55);
    end
    check_eq("st_wait_tag", cif.store_tag, 4'd7);
    step();
    drive(1'b1, 1'b1, 5'd0, 32'h100, 32'h55, 4'd7, 1'b1, 1'b1);
    check_eq("st_gnt_retire", cif.retire, 1'b1);
    check_eq("st_gnt_req", cif.store_req, 1'b1);
    step();
    drive(1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("st_done_req", cif.store_req, 1'b0);
    check_eq("st_done_busy", cif.busy, 1'b0);
    check_eq("st_done_retire", cif.retire, 1'b0);
    check_eq("st_hold_addr", cif.store_addr, 32'h100);
    check_eq("st_hold_data", cif.store_data, 32'h55);
    check_eq("st_no_timeout", cif.store_timeout, 1'b0);
`ifdef COMMIT_STATS_EN
    check_eq("stats_stall", cif.stall_cycles, 32'd3);
    check_eq("stats_store", cif.store_count, 32'd1);
    check_eq("stats_commit", cif.commit_count, 32'd4);
`endif

    // Timeout: 4 stalled cycles set the sticky flag.
    drive(1'b1, 1'b1, 5'd0, 32'h200, 32'h66, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("to_before", cif.store_timeout, 1'b0);
    end
    step();
    check_eq("to_set", cif.store_timeout, 1'b1);
    drive(1'b1, 1'b1, 5'd0, 32'h200, 32'h66, 4'd8, 1'b1, 1'b1);
    check_eq("to_gnt_retire", cif.retire, 1'b1);
    step();
    drive(1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("to_sticky", cif.store_timeout, 1'b1);
    check_eq("to_idle_busy", cif.busy, 1'b0);

    // Reset while a store is pending.
    drive(1'b1, 1'b1, 5'd0, 32'h300, 32'h99, 4'd1, 1'b1, 1'b0);
    step();
    check_eq("rst_mid_pre_req", cif.store_req, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd0, 32'h300, 32'h99, 4'd1, 1'b1, 1'b1);
    check_eq("rst_mid_retire_forced", cif.retire, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 32'h300, 32'h99, 4'd1, 1'b1, 1'b0);
    check_eq("rst_mid_req", cif.store_req, 1'b0);
    check_eq("rst_mid_addr", cif.store_addr, 32'h0);
    check_eq("rst_mid_retire", cif.retire, 1'b0);
    check_eq("rst_mid_busy", cif.busy, 1'b0);
    check_eq("rst_mid_timeout", cif.store_timeout, 1'b0);
    drive(1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
`ifdef COMMIT_STATS_EN
    check_eq("rst_mid_commit_count", cif.commit_count, 32'd0);
`endif

    // Back-to-back register commits, tags 0..3.
    for (int i = 0; i < 4; i++) exp_q.push_back(i[`ROB_TAG_LEN-1:0]);
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 1'b0, 5'(i + 1), '0, 32'(32'hA0 + i), i[`ROB_TAG_LEN-1:0], 1'b1, 1'b0);
      exp_tag = exp_q.pop_front();
      check_eq("b2b_retire", cif.retire, 1'b1);
      check_eq("b2b_mt_tag", cif.mt_clear_tag, exp_tag);
      check_eq("b2b_rf_idx", cif.rf_wr_idx, 5'(i + 1));
      check_eq("b2b_rf_data", cif.rf_wr_data, 32'(32'hA0 + i));
    end
    step();
    drive(1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 1'b0);
    check_eq("b2b_busy", cif.busy, 1'b0);
`ifdef COMMIT_STATS_EN
    check_eq("b2b_commit_count", cif.commit_count, 32'd4);
    check_eq("b2b_store_count", cif.store_count, 32'd0);
    check_eq("b2b_stall_cycles", cif.stall_cycles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
